// File: rtl/lelbc_pkg.sv
// lelbc_pkg: shared widths, FSM states, mode encoding and half-swap helper for the LELBC core.
package lelbc_pkg;
    localparam int BLK_W  = 64;
    localparam int HALF_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    function automatic logic [BLK_W-1:0] half_swap(input logic [BLK_W-1:0] x);
        return {x[HALF_W-1:0], x[BLK_W-1:HALF_W]};
    endfunction
endpackage

// File: rtl/lelbc_iter_core_if.sv
// lelbc_iter_core_if: block handshake and round-key write bus of the LELBC core.
interface lelbc_iter_core_if #(
    parameter int KEY_W = 128,
    parameter int IDX_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             out_mode;
    logic             key_we;
    logic [IDX_W-1:0] key_addr;
    logic [KEY_W-1:0] key_wdata;
    logic             key_err;
    logic             busy;

    modport master (
        output in_valid, in_data, in_mode, out_ready, key_we, key_addr, key_wdata,
        input  in_ready, out_valid, out_data, out_mode, key_err, busy
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready, key_we, key_addr, key_wdata,
        output in_ready, out_valid, out_data, out_mode, key_err, busy
    );
endinterface

// File: rtl/lelbc_round.sv
// lelbc_round: one combinational LELBC Feistel round, encrypt or decrypt form selected by mode.
module lelbc_round
    import lelbc_pkg::*;
#(
    parameter int KEY_W       = 128,
    parameter int IDX_W       = 5,
    parameter int SWAP_HALVES = 1
) (
    input  logic [BLK_W-1:0] data_i,
    input  logic [KEY_W-1:0] rkey_i,
    input  logic [IDX_W-1:0] ridx_i,
    input  logic             mode_i,
    output logic [BLK_W-1:0] data_o
);
    logic [HALF_W-1:0] l, r;

    function automatic logic [HALF_W-1:0] f(input logic [HALF_W-1:0] x);
        logic [HALF_W-1:0] t;
        t = (x ^ rkey_i[31:0]) + HALF_W'(ridx_i);
        return {t[26:0], t[31:27]} ^ (t + rkey_i[63:32]) ^ rkey_i[95:64] ^ (~t & rkey_i[127:96]);
    endfunction

    assign l = data_i[BLK_W-1:HALF_W];
    assign r = data_i[HALF_W-1:0];
    // With half swapping at the block edges, decryption reuses the encrypt round; otherwise it needs the true inverse.
    assign data_o = (mode_i == DEC && SWAP_HALVES == 0) ? {r ^ f(l), l} : {r, l ^ f(r)};
endmodule

// File: rtl/lelbc_iter_core.sv
// lelbc_iter_core: iterative LELBC encrypt/decrypt core, one shared round per cycle,
// valid/ready block handshakes and a loadable round-key file.
module lelbc_iter_core
    import lelbc_pkg::*;
#(
    parameter int ROUNDS      = 16,
    parameter int KEY_W       = 128,
    parameter int IDX_W       = 5,
    parameter int SWAP_HALVES = 1
) (
    input logic clk,
    input logic rst,
    lelbc_iter_core_if.slave bus
);
    localparam int AW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);
    localparam bit SWAP = SWAP_HALVES != 0;

    state_e st_q, st_d;
    logic [BLK_W-1:0] dat_q, dat_d, rnd;
    logic mode_q, mode_d, key_err_q, key_ok;
    logic [IDX_W-1:0] cnt_q, cnt_d, ridx;
    logic [AW-1:0] k;
    logic [KEY_W-1:0] rk_q [ROUNDS];

    assign key_ok = bus.key_we && st_q == IDLE && bus.key_addr < IDX_W'(ROUNDS);
    // Decryption walks the key file backwards, pairing each key with its encrypt round index.
    assign k    = AW'(mode_q ? ROUNDS - 1 - int'(cnt_q) : int'(cnt_q));
    assign ridx = IDX_W'(mode_q ? ROUNDS - int'(cnt_q) : int'(cnt_q) + 1);

    lelbc_round #(.KEY_W(KEY_W), .IDX_W(IDX_W), .SWAP_HALVES(SWAP_HALVES)) u_round (
        .data_i(dat_q),
        .rkey_i(rk_q[k]),
        .ridx_i(ridx),
        .mode_i(mode_q),
        .data_o(rnd)
    );

    always_comb begin
        st_d   = st_q;
        dat_d  = dat_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (st_q == IDLE && bus.in_valid) begin
            st_d   = RUN;
            dat_d  = (bus.in_mode == DEC && SWAP) ? half_swap(bus.in_data) : bus.in_data;
            mode_d = bus.in_mode;
            cnt_d  = '0;
        end else if (st_q == RUN) begin
            dat_d = rnd;
            cnt_d = cnt_q + 1'b1;
            st_d  = (cnt_q == LAST) ? DONE : RUN;
        end else if (st_q == DONE && bus.out_ready) begin
            st_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= IDLE;
            dat_q     <= '0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            key_err_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            dat_q     <= dat_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            key_err_q <= bus.key_we && !key_ok;
        end
    end

    // The key file survives reset so keys need not be reloaded after an abort.
    always_ff @(posedge clk) begin
        if (key_ok) rk_q[bus.key_addr[AW-1:0]] <= bus.key_wdata;
    end

    assign bus.in_ready  = st_q == IDLE;
    assign bus.out_valid = st_q == DONE;
    assign bus.out_data  = (st_q == DONE) ? ((mode_q == DEC && SWAP) ? half_swap(dat_q) : dat_q) : '0;
    assign bus.out_mode  = mode_q;
    assign bus.key_err   = key_err_q;
    assign bus.busy      = st_q != IDLE;
endmodule
